// File: rtl/countdown_pkg.sv
// Shared definitions for the seconds countdown control path.
// Holds the state encoding seen on the sequencer's `state` port and the
// default parameter values used for synthesis and simulation builds.
package countdown_pkg;

  // Encoding is visible on the `state` output port, so the values are fixed.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUNNING = 2'd1,
    ST_PAUSED  = 2'd2,
    ST_EXPIRED = 2'd3
  } state_e;

  // Width of the preset / seconds value.
  localparam int SEC_W_DEF    = 6;

  // Clock cycles per one-second tick: 100 MHz board clock vs. fast simulation.
  localparam int TICK_DIV_SYN = 100_000_000;
  localparam int TICK_DIV_SIM = 4;

  // Prescaler width large enough for TICK_DIV_SYN (2^27 > 100e6).
  localparam int PRESC_W_DEF  = 27;

endpackage

// File: rtl/tick_prescaler.sv
// One-second tick prescaler.
// Counts enabled cycles from 0 to TICK_DIV-1 and flags the wrap cycle.
//
// Ports:
//   clock   in   system clock
//   reset   in   synchronous, active-high reset (count -> 0)
//   enable  in   count this cycle; when low the count holds
//   clear   in   force the count to 0 at the next edge (wins over enable)
//   wrap    out  high in the cycle the count goes TICK_DIV-1 -> 0
module tick_prescaler #(
  parameter int TICK_DIV = 4,
  parameter int PRESC_W  = 3
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic wrap
);

  localparam logic [PRESC_W-1:0] LAST = PRESC_W'(TICK_DIV - 1);

  logic [PRESC_W-1:0] cnt_q;
  logic [PRESC_W-1:0] cnt_d;

  // Wrap is deliberately independent of clear: the caller already drops the
  // tick when it clears, and this keeps the caller's decode free of a loop.
  assign wrap = enable & (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (wrap) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = cnt_q + PRESC_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/countdown_sequencer.sv
// Control FSM for the seconds countdown datapath.
// Turns the start/pause/restart buttons into one-cycle events, runs the
// one-second prescaler and issues load/dec strobes to the countdown register.
// All outputs are registered: an event in cycle N shows up in cycle N+1.
//
// Ports:
//   clock          in   system clock
//   reset          in   synchronous, active-high reset
//   btn_start      in   start/resume request (level, debounced)
//   btn_pause      in   pause request (level, debounced)
//   btn_restart    in   restart request (level, debounced)
//   preset         in   seconds value captured on load
//   count_is_zero  in   datapath reports remaining count == 0
//   load           out  one-cycle pulse: datapath loads load_value
//   load_value     out  preset captured at the event cycle
//   dec            out  one-cycle pulse: datapath decrements by 1
//   running        out  high in RUNNING
//   paused         out  high in PAUSED
//   alarm          out  high in EXPIRED
//   state          out  encoded state (IDLE=0, RUNNING=1, PAUSED=2, EXPIRED=3)
module countdown_sequencer
  import countdown_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_SYN,
  parameter int PRESC_W  = PRESC_W_DEF,
  parameter int SEC_W    = SEC_W_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             btn_start,
  input  logic             btn_pause,
  input  logic             btn_restart,
  input  logic [SEC_W-1:0] preset,
  input  logic             count_is_zero,
  output logic             load,
  output logic [SEC_W-1:0] load_value,
  output logic             dec,
  output logic             running,
  output logic             paused,
  output logic             alarm,
  output logic [1:0]       state
);

  logic btn_start_q, btn_pause_q, btn_restart_q;
  logic evt_start, evt_pause, evt_restart;
  logic do_start, do_pause, do_restart;

  state_e           state_q, state_d;
  logic             load_q, load_d;
  logic [SEC_W-1:0] load_value_q, load_value_d;
  logic             dec_q, dec_d;
  logic             running_q, running_d;
  logic             paused_q, paused_d;
  logic             alarm_q, alarm_d;

  logic presc_en, presc_clr, wrap;

  // Rising-edge detect: a held button produces a single event.
  assign evt_start   = btn_start   & ~btn_start_q;
  assign evt_pause   = btn_pause   & ~btn_pause_q;
  assign evt_restart = btn_restart & ~btn_restart_q;

  // Same-cycle priority restart > pause > start; losers are dropped,
  // even when the winner is itself ignored in the current state.
  assign do_restart = evt_restart;
  assign do_pause   = evt_pause & ~evt_restart;
  assign do_start   = evt_start & ~evt_pause & ~evt_restart;

  // Prescaler runs only in RUNNING, holds in PAUSED so a resume keeps the
  // partial second, and restarts from 0 on every load.
  assign presc_en  = (state_q == ST_RUNNING);
  assign presc_clr = load_d | (state_q == ST_IDLE) | (state_q == ST_EXPIRED);

  tick_prescaler #(
    .TICK_DIV (TICK_DIV),
    .PRESC_W  (PRESC_W)
  ) u_presc (
    .clock  (clock),
    .reset  (reset),
    .enable (presc_en),
    .clear  (presc_clr),
    .wrap   (wrap)
  );

  always_comb begin
    state_d = state_q;
    load_d  = 1'b0;
    dec_d   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (do_restart || do_start) begin
          state_d = ST_RUNNING;
          load_d  = 1'b1;
        end
      end
      ST_RUNNING: begin
        if (do_restart) begin
          load_d = 1'b1;
        end else if (do_pause) begin
          // A wrap in this cycle is swallowed: no dec while pausing.
          state_d = ST_PAUSED;
        end else if (count_is_zero && !load_q) begin
          // During the load cycle count_is_zero still reflects the old count.
          state_d = ST_EXPIRED;
        end else if (wrap && !count_is_zero) begin
          dec_d = 1'b1;
        end
      end
      ST_PAUSED: begin
        if (do_restart) begin
          state_d = ST_RUNNING;
          load_d  = 1'b1;
        end else if (do_start) begin
          state_d = ST_RUNNING;
        end
      end
      ST_EXPIRED: begin
        if (do_restart || do_start) begin
          state_d = ST_RUNNING;
          load_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    load_value_d = load_d ? preset : load_value_q;
    running_d    = (state_d == ST_RUNNING);
    paused_d     = (state_d == ST_PAUSED);
    alarm_d      = (state_d == ST_EXPIRED);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      load_q        <= 1'b0;
      load_value_q  <= '0;
      dec_q         <= 1'b0;
      running_q     <= 1'b0;
      paused_q      <= 1'b0;
      alarm_q       <= 1'b0;
      btn_start_q   <= 1'b0;
      btn_pause_q   <= 1'b0;
      btn_restart_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      load_q        <= load_d;
      load_value_q  <= load_value_d;
      dec_q         <= dec_d;
      running_q     <= running_d;
      paused_q      <= paused_d;
      alarm_q       <= alarm_d;
      btn_start_q   <= btn_start;
      btn_pause_q   <= btn_pause;
      btn_restart_q <= btn_restart;
    end
  end

  assign load       = load_q;
  assign load_value = load_value_q;
  assign dec        = dec_q;
  assign running    = running_q;
  assign paused     = paused_q;
  assign alarm      = alarm_q;
  assign state      = state_q;

endmodule

// File: tb/tb_countdown_sequencer.sv
// Bench for countdown_sequencer with TICK_DIV=4 and a 6-bit datapath model.
// Timed sequences push expected load/dec/alarm events into a queue; a monitor
// pops and compares them as the DUT produces them. A table of one-cycle
// transitions covers the state/priority matrix.
module tb_countdown_sequencer;

  localparam int TICK_DIV = 4;
  localparam int PRESC_W  = 3;
  localparam int SEC_W    = 6;

  localparam int EV_LOAD  = 0;
  localparam int EV_DEC   = 1;
  localparam int EV_ALARM = 2;

  logic             clock = 1'b0;
  logic             reset;
  logic             btn_start, btn_pause, btn_restart;
  logic [SEC_W-1:0] preset;
  logic             count_is_zero;
  logic             load;
  logic [SEC_W-1:0] load_value;
  logic             dec;
  logic             running, paused, alarm;
  logic [1:0]       state;

  countdown_sequencer #(
    .TICK_DIV (TICK_DIV),
    .PRESC_W  (PRESC_W),
    .SEC_W    (SEC_W)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .btn_start     (btn_start),
    .btn_pause     (btn_pause),
    .btn_restart   (btn_restart),
    .preset        (preset),
    .count_is_zero (count_is_zero),
    .load          (load),
    .load_value    (load_value),
    .dec           (dec),
    .running       (running),
    .paused        (paused),
    .alarm         (alarm),
    .state         (state)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Countdown datapath model.
  logic [SEC_W-1:0] dp_cnt;
  always @(posedge clock) begin
    if (reset)     dp_cnt <= '0;
    else if (load) dp_cnt <= load_value;
    else if (dec)  dp_cnt <= dp_cnt - 1'b1;
  end
  assign count_is_zero = (dp_cnt == '0);

  typedef struct {
    int kind;
    int cyc;
    int val;
  } ev_t;
  ev_t exp_q[$];

  int n_cmp = 0;
  int n_bad = 0;
  bit mon_en = 1'b0;
  logic alarm_prev = 1'b0;

  task automatic push_ev(int kind, int c, int val);
    ev_t e;
    e.kind = kind;
    e.cyc  = c;
    e.val  = val;
    exp_q.push_back(e);
  endtask

  task automatic check_ev(int kind, int val);
    ev_t e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL unexpected_event: got kind=%0d val=%0d at cycle %0d, required none", kind, val, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.cyc != cyc || e.val != val) begin
        n_bad++;
        $display("FAIL event_order: got kind=%0d cycle=%0d val=%0d, required kind=%0d cycle=%0d val=%0d",
                 kind, cyc, val, e.kind, e.cyc, e.val);
      end
    end
  endtask

  // Event monitor, sampling on the inactive clock edge.
  always @(negedge clock) begin
    if (mon_en) begin
      if (load) check_ev(EV_LOAD, int'(load_value));
      if (dec) begin
        check_ev(EV_DEC, 0);
        n_cmp++;
        if (dp_cnt == '0) begin
          n_bad++;
          $display("FAIL dec_at_zero: got dec with count=%0d at cycle %0d, required count>0", dp_cnt, cyc);
        end
      end
      if (alarm && !alarm_prev) check_ev(EV_ALARM, 0);
    end
    alarm_prev <= alarm;
  end

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic check(string name, int got, int req);
    n_cmp++;
    if (got != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, got, req, cyc);
    end
  endtask

  task automatic expect_drained(string name);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL %s: %0d expected events never seen, first kind=%0d cycle=%0d",
               name, exp_q.size(), exp_q[0].kind, exp_q[0].cyc);
      exp_q.delete();
    end
  endtask

  task automatic check_all_zero(string name);
    check({name, "_state"},   int'(state),      0);
    check({name, "_load"},    int'(load),       0);
    check({name, "_lval"},    int'(load_value), 0);
    check({name, "_dec"},     int'(dec),        0);
    check({name, "_running"}, int'(running),    0);
    check({name, "_paused"},  int'(paused),     0);
    check({name, "_alarm"},   int'(alarm),      0);
  endtask

  task automatic do_reset(int n);
    reset = 1'b1;
    repeat (n) tick();
    reset = 1'b0;
  endtask

  // Transition table: from-state, buttons in one cycle, expected next outputs.
  typedef struct {
    logic [1:0] from;
    logic       r, p, s;
    logic [1:0] exp_state;
    logic       exp_load;
  } vec_t;
  vec_t vq[$];

  task automatic add_vec(logic [1:0] from, logic r, logic p, logic s,
                         logic [1:0] es, logic el);
    vec_t v;
    v.from = from; v.r = r; v.p = p; v.s = s;
    v.exp_state = es; v.exp_load = el;
    vq.push_back(v);
  endtask

  task automatic go_state(logic [1:0] st);
    do_reset(2);
    if (st != 2'd0) begin
      preset = (st == 2'd3) ? 6'd0 : 6'd40;
      btn_start = 1'b1;
      tick();
      btn_start = 1'b0;
      tick();
      if (st == 2'd3) repeat (2) tick();
      if (st == 2'd2) begin
        btn_pause = 1'b1;
        tick();
        btn_pause = 1'b0;
        tick();
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t, p, s;
    reset = 1'b1;
    btn_start = 1'b0;
    btn_pause = 1'b0;
    btn_restart = 1'b0;
    preset = '0;

    // Reset state.
    while (cyc < 3) tick();
    check_all_zero("reset");
    reset = 1'b0;
    mon_en = 1'b1;

    // Sequence 1: preset 3, start pulse at cycle 10.
    while (cyc < 10) tick();
    preset = 6'd3;
    btn_start = 1'b1;
    push_ev(EV_LOAD, 11, 3);
    push_ev(EV_DEC, 15, 0);
    push_ev(EV_DEC, 19, 0);
    push_ev(EV_DEC, 23, 0);
    push_ev(EV_ALARM, 25, 0);
    tick();
    btn_start = 1'b0;
    while (cyc < 24) tick();
    check("seq1_state_c24", int'(state), 1);
    tick();
    check("seq1_state_c25", int'(state), 3);
    check("seq1_alarm_c25", int'(alarm), 1);
    while (cyc < 32) tick();
    expect_drained("seq1_drain");

    // Sequence 2: pause after first dec, held 20 cycles, then resume.
    preset = 6'd5;
    t = cyc;
    btn_start = 1'b1;
    push_ev(EV_LOAD, t + 1, 5);
    push_ev(EV_DEC, t + 5, 0);
    tick();
    btn_start = 1'b0;
    while (cyc < t + 6) tick();
    p = cyc;
    btn_pause = 1'b1;
    tick();
    check("seq2_paused", int'(paused), 1);
    check("seq2_state_paused", int'(state), 2);
    while (cyc < p + 20) tick();
    btn_pause = 1'b0;
    while (cyc < p + 22) tick();
    check("seq2_still_paused", int'(paused), 1);
    s = cyc;
    btn_start = 1'b1;
    push_ev(EV_DEC, s + 3, 0);
    push_ev(EV_DEC, s + 7, 0);
    push_ev(EV_DEC, s + 11, 0);
    push_ev(EV_DEC, s + 15, 0);
    push_ev(EV_ALARM, s + 17, 0);
    tick();
    btn_start = 1'b0;
    check("seq2_resume_running", int'(running), 1);
    while (cyc < s + 22) tick();
    expect_drained("seq2_drain");

    // Sequence 3: preset 0 expires right after load, no dec.
    preset = 6'd0;
    t = cyc;
    btn_start = 1'b1;
    push_ev(EV_LOAD, t + 1, 0);
    push_ev(EV_ALARM, t + 3, 0);
    tick();
    btn_start = 1'b0;
    tick();
    check("seq3_guard_state", int'(state), 1);
    while (cyc < t + 14) tick();
    expect_drained("seq3_drain");
    check("seq3_state", int'(state), 3);

    // Sequence 4: restart+pause+start together while RUNNING with count=2.
    preset = 6'd2;
    t = cyc;
    btn_start = 1'b1;
    push_ev(EV_LOAD, t + 1, 2);
    tick();
    btn_start = 1'b0;
    while (cyc < t + 3) tick();
    check("seq4_count_before", int'(dp_cnt), 2);
    btn_restart = 1'b1;
    btn_pause = 1'b1;
    btn_start = 1'b1;
    push_ev(EV_LOAD, t + 4, 2);
    push_ev(EV_DEC, t + 8, 0);
    push_ev(EV_DEC, t + 12, 0);
    push_ev(EV_ALARM, t + 14, 0);
    tick();
    btn_restart = 1'b0;
    btn_pause = 1'b0;
    btn_start = 1'b0;
    check("seq4_paused", int'(paused), 0);
    check("seq4_state", int'(state), 1);
    while (cyc < t + 20) tick();
    expect_drained("seq4_drain");

    // Sequence 5: start held 50 cycles from IDLE, preset 5.
    do_reset(2);
    check("seq5_idle", int'(state), 0);
    preset = 6'd5;
    t = cyc;
    btn_start = 1'b1;
    push_ev(EV_LOAD, t + 1, 5);
    for (int i = 0; i < 5; i++) push_ev(EV_DEC, t + 5 + 4 * i, 0);
    push_ev(EV_ALARM, t + 23, 0);
    repeat (50) tick();
    btn_start = 1'b0;
    repeat (5) tick();
    expect_drained("seq5_drain");
    check("seq5_state", int'(state), 3);

    // Sequence 6: reset between two decs aborts the run.
    preset = 6'd10;
    t = cyc;
    btn_start = 1'b1;
    push_ev(EV_LOAD, t + 1, 10);
    push_ev(EV_DEC, t + 5, 0);
    push_ev(EV_DEC, t + 9, 0);
    tick();
    btn_start = 1'b0;
    while (cyc < t + 11) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_all_zero("seq6_reset");
    repeat (20) tick();
    expect_drained("seq6_drain");
    check("seq6_state", int'(state), 0);

    // Transition table.
    mon_en = 1'b0;
    add_vec(2'd0, 0, 0, 1, 2'd1, 1);
    add_vec(2'd0, 1, 0, 0, 2'd1, 1);
    add_vec(2'd0, 0, 1, 0, 2'd0, 0);
    add_vec(2'd0, 0, 1, 1, 2'd0, 0);
    add_vec(2'd1, 0, 1, 0, 2'd2, 0);
    add_vec(2'd1, 1, 0, 0, 2'd1, 1);
    add_vec(2'd1, 0, 0, 1, 2'd1, 0);
    add_vec(2'd1, 0, 1, 1, 2'd2, 0);
    add_vec(2'd1, 1, 1, 1, 2'd1, 1);
    add_vec(2'd2, 0, 0, 1, 2'd1, 0);
    add_vec(2'd2, 1, 0, 0, 2'd1, 1);
    add_vec(2'd2, 0, 1, 0, 2'd2, 0);
    add_vec(2'd2, 1, 1, 1, 2'd1, 1);
    add_vec(2'd3, 1, 0, 0, 2'd1, 1);
    add_vec(2'd3, 0, 0, 1, 2'd1, 1);
    add_vec(2'd3, 0, 1, 0, 2'd3, 0);

    for (int i = 0; i < vq.size(); i++) begin
      logic [5:0] got, req;
      go_state(vq[i].from);
      check($sformatf("tbl%0d_setup", i), int'(state), int'(vq[i].from));
      btn_restart = vq[i].r;
      btn_pause   = vq[i].p;
      btn_start   = vq[i].s;
      tick();
      btn_restart = 1'b0;
      btn_pause   = 1'b0;
      btn_start   = 1'b0;
      got = {state, load, running, paused, alarm};
      req = {vq[i].exp_state, vq[i].exp_load,
             vq[i].exp_state == 2'd1, vq[i].exp_state == 2'd2, vq[i].exp_state == 2'd3};
      check($sformatf("tbl%0d_outputs", i), int'(got), int'(req));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
